// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: op and state encodings plus the STEP legality check.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_ROTR = 2'b10,
        OP_SRA  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic bit step_is_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4) || (step == 8) || (step == 16);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step by k bits (0..STEP). Rotate-right on op 10 only when SHIFT_ROTATE_EN
// is defined; otherwise op 10 falls through to SLL.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K_WIDTH    = 3
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [K_WIDTH-1:0]    k_i,
    input  op_e                   op_i,
    input  logic                  sign_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] sra_fill;

    // Vacated high bits for SRA: ones in the top k positions, gated by the captured sign.
    assign sra_fill = ~({DATA_WIDTH{1'b1}} >> k_i) & {DATA_WIDTH{sign_i}};

`ifdef SHIFT_ROTATE_EN
    localparam int RW = $clog2(DATA_WIDTH) + 1;
    logic [RW-1:0] rot_back;
    assign rot_back = RW'(DATA_WIDTH) - RW'(k_i);
`endif

    // NOTE: every path assigns data_o (default arm included), so no latch is inferred.
    always_comb begin
        case (op_i)
            OP_SRL:  data_o = data_i >> k_i;
            OP_SRA:  data_o = (data_i >> k_i) | sra_fill;
`ifdef SHIFT_ROTATE_EN
            OP_ROTR: data_o = (data_i >> k_i) | (data_i << rot_back);
`endif
            default: data_o = data_i << k_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_iterative.sv
// Iterative EX-stage shifter: up to STEP bits per cycle with a start/busy/done handshake.
// Optional rotate-right on op 10 is enabled by defining SHIFT_ROTATE_EN.
module shift_unit_iterative
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_start_1,
    input  logic [DATA_WIDTH-1:0]  in_operand_32,
    input  logic [SHAMT_WIDTH-1:0] in_shamt_5,
    input  logic [1:0]             in_op_2,
    output logic [DATA_WIDTH-1:0]  out_result_32,
    output logic                   out_busy_1,
    output logic                   out_done_1
);

    localparam int KW = $clog2(STEP + 1);

    if (!step_is_legal(STEP)) begin : g_bad_step
        $error("shift_unit_iterative: STEP must be 1, 2, 4, 8 or 16");
    end

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
    op_e                    op_q, op_d;
    logic                   sign_q, sign_d;

    logic [KW-1:0]          k;
    logic [DATA_WIDTH-1:0]  step_out;

    always_comb begin
        if (int'(rem_q) > STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
    end

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .K_WIDTH    (KW)
    ) u_step (
        .data_i (work_q),
        .k_i    (k),
        .op_i   (op_q),
        .sign_i (sign_q),
        .data_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (in_start_1) begin
                    work_d = in_operand_32;
                    op_d   = op_e'(in_op_2);
                    sign_d = in_operand_32[DATA_WIDTH-1];
                    rem_d  = in_shamt_5;
                    if (in_shamt_5 == '0) begin
                        state_d  = DONE;
                        result_d = in_operand_32;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - SHAMT_WIDTH'(k);
                // Result is registered on the final step so it is already valid in the DONE cycle.
                if (rem_q == SHAMT_WIDTH'(k)) begin
                    state_d  = DONE;
                    result_d = step_out;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
        end
    end

    assign out_result_32 = result_q;
    assign out_busy_1    = (state_q == SHIFT);
    assign out_done_1    = (state_q == DONE);

endmodule

// File: doc/shift_unit_iterative.md
Name: shift_unit_iterative

Overview:
Multi-cycle shifter in the EX stage, directly downstream of the shamt select mux. It consumes the selected 5-bit shift amount, an operand and a shift opcode, then shifts iteratively by up to STEP bits per cycle. Control uses a start/busy/done handshake, so the hazard unit can stall the pipeline while a shift is in progress.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_WIDTH, 5, shift amount width; max shift 2**SHAMT_WIDTH-1
STEP, 4, max bits shifted per cycle; legal values 1, 2, 4, 8, 16; other values are a compile-time error

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_start_1  input  1  start request; sampled only in IDLE
in_operand_32  input  DATA_WIDTH  value to shift (rt)
in_shamt_5  input  SHAMT_WIDTH  shift amount from shamt mux
in_op_2  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (see Optional Feature)
out_result_32  output  DATA_WIDTH  shifted result; held until the next accepted start
out_busy_1  output  1  high from the cycle after start acceptance until done
out_done_1  output  1  single-cycle pulse when out_result_32 becomes valid

Behaviour:
- Reset (reset=0, async): state=IDLE; out_result_32=0, out_busy_1=0, out_done_1=0; internal remaining count=0.
- States: IDLE, SHIFT, DONE.
- IDLE + in_start_1=1: latch operand, op and shamt into a working register and remaining count.
  - If shamt==0: go to DONE.
  - Else: go to SHIFT.
- IDLE + in_start_1=0: stay in IDLE; outputs hold.
- SHIFT, each cycle:
  - k = min(remaining, STEP); shift the working register by k per op; remaining -= k.
  - When remaining reaches 0 in this update, go to DONE.
- DONE:
  - out_result_32 = working register.
  - out_done_1 = 1 for exactly this cycle.
  - out_busy_1 = 0.
  - Next state is IDLE.
- out_busy_1 = 1 exactly while state==SHIFT.
- Latency from the accepting edge to the done pulse = ceil(shamt/STEP)+1 cycles. shamt=0 gives 1 cycle. shamt=31 with STEP=4 gives 9 cycles.
- in_start_1 while in SHIFT or DONE is ignored; there is no queueing. A start is accepted in IDLE only, including the cycle immediately after DONE.
- Shift semantics:
  - SLL and SRL fill with zero.
  - SRA replicates the bit at DATA_WIDTH-1, captured at start.
  - Shifts never exceed DATA_WIDTH-1.
- Inputs are sampled only on the accepting edge; later changes to them have no effect.
- Reset asserted mid-operation aborts immediately to IDLE with the reset values above. No done pulse is produced for the aborted shift.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: op 10 = ROTR (MIPS32r2). Each step rotates right by k; bits leaving bit 0 re-enter at bit DATA_WIDTH-1. Latency is the same as the other ops.
- Undefined: op 10 behaves exactly as SLL. No rotate logic is synthesised.

Decomposition:
- Package shift_pkg: op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_ROTR=2'b10, OP_SRA=2'b11; state encoding IDLE/SHIFT/DONE; STEP legality check function.
- Sub-module shift_step: purely combinational, one-step shifter. Inputs: data, k (0..STEP), op, sign bit. Output: shifted data. Instantiated once in the SHIFT datapath.

Test Plan:
- reset=0 mid-SHIFT (operand 0xFFFF0000, SRA, shamt 20) -> next edge in IDLE; result 0, busy 0; no done pulse.
- SLL operand 0x00000001, shamt 31, STEP=4 -> busy high 8 cycles; done pulse on cycle 9; result 0x80000000.
- SRA operand 0x80000000, shamt 4 -> result 0xF8000000 after 2 cycles; same with SRL -> 0x08000000.
- shamt 0, operand 0xDEADBEEF, any op -> done on the next cycle; busy never high; result 0xDEADBEEF.
- start held high continuously through three back-to-back SRL ops (shamt 8 on 0x12345678, then new operands) -> second start accepted only in the IDLE cycle after the done pulse; first result 0x00123456, later operand changes ignored while busy.
- op 10, operand 0x0000000F, shamt 4 -> with SHIFT_ROTATE_EN: 0xF0000000; without: 0x000000F0.
